// File: rtl/spart_tx_framer_if.sv
// Handshake bundle between game logic / SPART and the transmit framer.
// The framer takes the slave side; the driver of payload and tbr is master.
interface spart_tx_framer_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       start;
    logic [3:0] len;
    logic       busy;
    logic       done;
    logic       send_tx;
    logic [7:0] tx_data;
    logic       tbr;

    modport master (
        output wr_en, wr_data, start, len, tbr,
        input  full, empty, busy, done, send_tx, tx_data
    );

    modport slave (
        input  wr_en, wr_data, start, len, tbr,
        output full, empty, busy, done, send_tx, tx_data
    );
endinterface

// File: rtl/spart_tx_framer.sv
// Packet framer: emits SYNC, LEN, payload, checksum to the SPART
// one byte per transmit-buffer cycle, fed from a small payload FIFO.
module spart_tx_framer #(
    parameter int         DEPTH = 8,
    parameter logic [7:0] SYNC  = 8'hA5
) (
    input logic               clk,
    input logic               rst_n,
    spart_tx_framer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LEN, S_PAY,
        S_CSUM, S_WAITLO, S_WAITHI
    } state_t;

    state_t state, state_nx, ret_q;

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr, count;
    logic        push, pop, issue, fin;
    logic        full_w, empty_w;
    logic [7:0]  byte_nx, csum, tx_q;
    logic [3:0]  rem_cnt, len_reg;
    logic        send_q, busy_q, done_q;

    assign count   = wptr - rptr;
    assign full_w  = (count == (AW+1)'(DEPTH));
    assign empty_w = (count == '0);
    assign push    = bus.wr_en && (!full_w || pop);

    assign bus.full    = full_w;
    assign bus.empty   = empty_w;
    assign bus.send_tx = send_q;
    assign bus.tx_data = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:
                if (bus.start) state_nx = S_HDR;
            S_HDR, S_LEN, S_PAY, S_CSUM:
                if (issue) state_nx = S_WAITLO;
            S_WAITLO:
                if (!bus.tbr) state_nx = S_WAITHI;
            S_WAITHI:
                if (bus.tbr) begin
                    unique case (ret_q)
                        S_HDR:  state_nx = S_LEN;
                        S_LEN:  state_nx = (len_reg != '0)
                                         ? S_PAY : S_CSUM;
                        S_PAY:  state_nx = (rem_cnt != '0)
                                         ? S_PAY : S_CSUM;
                        default: state_nx = S_IDLE;
                    endcase
                end
            default: state_nx = S_IDLE;
        endcase
    end

    // Byte selection and strobe decision; registered below.
    always_comb begin
        issue   = 1'b0;
        pop     = 1'b0;
        byte_nx = csum;
        unique case (state)
            S_HDR: begin
                issue   = bus.tbr;
                byte_nx = SYNC;
            end
            S_LEN: begin
                issue   = bus.tbr;
                byte_nx = {4'b0, len_reg};
            end
            S_PAY: begin
                issue   = bus.tbr && !empty_w;
                pop     = issue;
                byte_nx = mem[rptr[AW-1:0]];
            end
            S_CSUM: begin
                issue   = bus.tbr;
                byte_nx = csum;
            end
            default: ;
        endcase
    end

    assign fin = (state == S_WAITHI) && bus.tbr
              && (ret_q == S_CSUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_q  <= 1'b0;
            tx_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ret_q   <= S_HDR;
            rem_cnt <= '0;
            len_reg <= '0;
            csum    <= '0;
        end else begin
            send_q <= issue;
            done_q <= fin;
            if (issue) begin
                tx_q  <= byte_nx;
                ret_q <= state;
            end
            if (state == S_IDLE && bus.start) begin
                rem_cnt <= bus.len;
                len_reg <= bus.len;
                csum    <= '0;
                busy_q  <= 1'b1;
            end
            if (fin) busy_q <= 1'b0;
            if (issue && (state == S_LEN || state == S_PAY))
                csum <= csum + byte_nx;
            if (pop) rem_cnt <= rem_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= bus.wr_data;
    end
endmodule
